// File: rtl/p_5_pkg.sv
// Shared definitions for the p_5 AND/OR cell and its stimulus driver.
package p_5_pkg;

    // Driver sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reference behaviour of the p_5 cell: OR when c is set, AND otherwise.
    function automatic logic p5_ref(input logic a, input logic b, input logic c);
        return c ? (a | b) : (a & b);
    endfunction

endpackage

// File: rtl/p_5_drv_if.sv
// Operand/result bus between the driver (master) and the p_5 cell (slave).
interface p_5_drv_if;
    logic A;
    logic B;
    logic C;
    logic CE;
    logic Q;

    modport master (output A, output B, output C, output CE, input Q);
    modport slave  (input A, input B, input C, input CE, output Q);
endinterface

// File: rtl/p_5_chk.sv
// Result checker: remembers what was issued last cycle and compares it
// against the registered Q coming back from the cell.
module p_5_chk
    import p_5_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ce,
    input  logic [2:0]       abc,
    input  logic             q,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       last_fail
);

    logic       pend_v;
    logic       pend_exp;
    logic [2:0] pend_abc;

    // Capture the expectation of each issued vector; pend_v tracks CE exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v   <= 1'b0;
            pend_exp <= 1'b0;
            pend_abc <= '0;
        end else begin
            pend_v <= ce;
            if (ce) begin
                pend_exp <= p5_ref(abc[2], abc[1], abc[0]);
                pend_abc <= abc;
            end
        end
    end

    // Compare the returned Q; saturating mismatch count and last failing code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            last_fail <= '0;
        end else if (clr) begin
            err_cnt   <= '0;
            last_fail <= '0;
        end else if (pend_v && (q != pend_exp)) begin
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
            last_fail <= pend_abc;
        end
    end

endmodule

// File: rtl/p_5_drv.sv
// Stimulus driver for the p_5 cell: walks {A,B,C} through NUM_VEC codes,
// drives CE per accepted vector and checks the returned Q in-system.
module p_5_drv
    import p_5_pkg::*;
#(
    parameter int NUM_VEC = 8,
    parameter int CNT_W   = 4
) (
    input  logic             CLK,
    input  logic             Clr_n,
    input  logic             Start,
    input  logic             Hold,
    p_5_drv_if.master        bus,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Err_cnt,
    output logic [2:0]       Last_fail
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [2:0] abc;
    logic       ce;
    logic       start_acc;

    // State register.
    always_ff @(posedge CLK or negedge Clr_n) begin
        if (!Clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and CE decode; CE follows ~Hold combinationally in DRIVE.
    always_comb begin
        state_nxt = state;
        ce        = 1'b0;
        start_acc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                ce = ~Hold;
                if (ce && (idx == LAST_IDX)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Vector index and registered operands; both hold while Hold is high.
    always_ff @(posedge CLK or negedge Clr_n) begin
        if (!Clr_n) begin
            idx <= '0;
            abc <= '0;
        end else if (start_acc) begin
            idx <= '0;
            abc <= '0;
        end else if (ce && (idx != LAST_IDX)) begin
            idx <= idx + 3'd1;
            abc <= idx + 3'd1;
        end
    end

    p_5_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk       (CLK),
        .rst_n     (Clr_n),
        .clr       (start_acc),
        .ce        (ce),
        .abc       (abc),
        .q         (bus.Q),
        .err_cnt   (Err_cnt),
        .last_fail (Last_fail)
    );

    assign bus.A  = abc[2];
    assign bus.B  = abc[1];
    assign bus.C  = abc[0];
    assign bus.CE = ce;
    assign Busy   = (state == ST_DRIVE) || (state == ST_DRAIN);
    assign Done   = (state == ST_DONE);

endmodule

// File: tb/tb_p_5_drv.sv
// Scoreboard bench for p_5_drv with a behavioural p_5 cell in the loop.
module tb_p_5_drv;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    logic start = 1'b0;
    logic hold  = 1'b0;
    int   mode  = 0;      // 0: correct cell, 1: Q forced to 1
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ce_cnt = 0;
    logic done_seen = 1'b0;

    typedef struct {
        int cyc;
        int err;
        int lf;
    } done_t;

    logic [2:0] vq[$];
    done_t      dq[$];
    logic [2:0] exp_v;
    done_t      exp_d;

    p_5_drv_if bus1();
    p_5_drv_if bus2();

    logic       busy1, done1, busy2, done2;
    logic [3:0] err1;
    logic [1:0] err2;
    logic [2:0] lf1, lf2;
    logic       cell1, cell2;

    p_5_drv #(.NUM_VEC(8), .CNT_W(4)) u1 (
        .CLK(clk), .Clr_n(clr_n), .Start(start), .Hold(hold), .bus(bus1),
        .Busy(busy1), .Done(done1), .Err_cnt(err1), .Last_fail(lf1)
    );

    p_5_drv #(.NUM_VEC(8), .CNT_W(2)) u2 (
        .CLK(clk), .Clr_n(clr_n), .Start(start), .Hold(hold), .bus(bus2),
        .Busy(busy2), .Done(done2), .Err_cnt(err2), .Last_fail(lf2)
    );

    // Behavioural p_5 cells: registered C ? A|B : A&B, enabled by CE.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cell1 <= 1'b0;
            cell2 <= 1'b0;
        end else begin
            if (bus1.CE) cell1 <= bus1.C ? (bus1.A | bus1.B) : (bus1.A & bus1.B);
            if (bus2.CE) cell2 <= bus2.C ? (bus2.A | bus2.B) : (bus2.A & bus2.B);
        end
    end

    assign bus1.Q = (mode == 1) ? 1'b1 : cell1;
    assign bus2.Q = ~cell2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a vector or Done.
    always @(negedge clk) begin
        if (clr_n) begin
            if (bus1.CE) begin
                ce_cnt++;
                if (vq.size() == 0) begin
                    chk("unexpected_ce", 1, 0);
                end else begin
                    exp_v = vq.pop_front();
                    chk("vector", {bus1.A, bus1.B, bus1.C}, exp_v);
                end
            end
            if (hold && busy1 && vq.size() > 0) begin
                chk("hold_ce", bus1.CE, 0);
                chk("hold_abc", {bus1.A, bus1.B, bus1.C}, vq[0]);
            end
            if (done1) begin
                done_seen = 1'b1;
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_d = dq.pop_front();
                    chk("done_cycle", cyc, exp_d.cyc);
                    chk("err_cnt", err1, exp_d.err);
                    chk("last_fail", lf1, exp_d.lf);
                end
            end
            if (done2) begin
                chk("sat_err_cnt", err2, 3);
                chk("sat_last_fail", lf2, 7);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a Start and queue the expected vectors and end-of-run result.
    task automatic issue(input int hold_n, input int e_err, input int e_lf);
        tick();
        start = 1'b1;
        for (int k = 0; k < 8; k++) vq.push_back(3'(k));
        dq.push_back('{cyc + 10 + hold_n, e_err, e_lf});
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int ce_before);
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) tick();
        if (!done_seen) chk("done_timeout", 0, 1);
        chk("ce_count", ce_cnt - ce_before, 8);
        chk("vq_empty", vq.size(), 0);
    endtask

    initial begin
        int ce0;
        int found;

        // Reset state.
        #1;
        chk("rst_ce", bus1.CE, 0);
        chk("rst_abc", {bus1.A, bus1.B, bus1.C}, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_err", err1, 0);
        chk("rst_lf", lf1, 0);
        repeat (3) tick();
        clr_n = 1'b1;
        repeat (2) tick();

        // Correct loopback, with a stray Start during DRIVE.
        mode = 0;
        ce0  = ce_cnt;
        issue(0, 0, 0);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(ce0);
        repeat (3) tick();
        chk("idle_busy", busy1, 0);
        chk("err_hold", err1, 0);

        // Q forced to 1: vectors 0,1,2,4 mismatch.
        mode = 1;
        ce0  = ce_cnt;
        issue(0, 4, 4);
        wait_done(ce0);
        repeat (3) tick();
        chk("err_hold_after_done", err1, 4);
        chk("lf_hold_after_done", lf1, 4);

        // Hold for 3 cycles while vector 5 is pending.
        mode = 0;
        ce0  = ce_cnt;
        issue(3, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if ({bus1.A, bus1.B, bus1.C} == 3'd5 && busy1) found = 1;
            else tick();
        end
        chk("reach_vec5", found, 1);
        hold = 1'b1;
        repeat (3) tick();
        hold = 1'b0;
        wait_done(ce0);

        // Reset mid-run at vector 4 with mismatches already counted.
        mode = 1;
        issue(0, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if ({bus1.A, bus1.B, bus1.C} == 3'd4 && busy1) found = 1;
            else tick();
        end
        chk("reach_vec4", found, 1);
        chk("pre_abort_err", err1, 3);
        chk("pre_abort_lf", lf1, 2);
        clr_n = 1'b0;
        #1;
        vq.delete();
        dq.delete();
        chk("abort_ce", bus1.CE, 0);
        chk("abort_abc", {bus1.A, bus1.B, bus1.C}, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_err", err1, 0);
        chk("abort_lf", lf1, 0);
        chk("abort_err2", err2, 0);
        repeat (3) tick();
        clr_n = 1'b1;
        repeat (15) tick();
        chk("abort_idle", busy1, 0);

        // Fresh run after the abort completes normally.
        mode = 0;
        ce0  = ce_cnt;
        issue(0, 0, 0);
        wait_done(ce0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
